alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 135 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Single-issue controller between an instruction stream and a handshaked ALU.
// Owns an 8x16 register file and steers ALU results to writeback, address or branch strobes.
module alu_issue_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic        aluMode,
    output logic [2:0]  op,
    output logic [15:0] rd1,
    output logic [15:0] rd2,
    output logic [5:0]  offset,
    output logic        execute,
    input  logic [15:0] result,
    input  logic        executeComplete,
    input  logic        branchExecute,
    output logic        resetALU,
    output logic        addr_valid,
    output logic [15:0] addr,
    output logic        br_taken,
    output logic        br_not_taken,
    output logic        illegal,
    output logic        timeout_err
);

    typedef enum logic [2:0] {IDLE, DECODE, ISSUE, WAIT, RELEASE, DRAIN} state_t;

    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    state_t         state;
    logic [15:0]    regs [8];
    logic [2:0]     rd_idx;
    logic [CW-1:0]  wait_cnt;

    // The ALU must have dropped both done flags before a new instruction may be taken.
    assign instr_ready = rst_n && (state == IDLE) && !executeComplete && !branchExecute;

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values; blocking assignments would make results depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            // NOTE: the register file is small and must read zero after reset, so it is
            // built from resettable flops rather than an inferred RAM.
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            aluMode      <= 1'b0;
            op           <= '0;
            rd1          <= '0;
            rd2          <= '0;
            offset       <= '0;
            rd_idx       <= '0;
            wait_cnt     <= '0;
            execute      <= 1'b0;
            resetALU     <= 1'b0;
            addr_valid   <= 1'b0;
            addr         <= '0;
            br_taken     <= 1'b0;
            br_not_taken <= 1'b0;
            illegal      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            execute      <= 1'b0;
            resetALU     <= 1'b0;
            addr_valid   <= 1'b0;
            br_taken     <= 1'b0;
            br_not_taken <= 1'b0;
            illegal      <= 1'b0;

            case (state)
                IDLE: begin
                    // Operands are captured on accept so they are already stable
                    // during DECODE, a full cycle before execute rises in ISSUE.
                    if (instr_valid && instr_ready) begin
                        aluMode <= instr[15];
                        op      <= instr[14:12];
                        rd1     <= regs[instr[11:9]];
                        rd2     <= regs[instr[8:6]];
                        rd_idx  <= instr[5:3];
                        offset  <= instr[5:0];
                        state   <= DECODE;
                    end
                end

                DECODE: begin
                    if (!aluMode && op >= 3'd3) begin
                        illegal <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        execute  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= ISSUE;
                    end
                end

                ISSUE: state <= WAIT;

                WAIT: begin
                    if (executeComplete || branchExecute) begin
                        resetALU <= 1'b1;
                        state    <= RELEASE;
                        if (aluMode) begin
                            if (rd_idx != 3'd0) regs[rd_idx] <= result;
                        end else if (op == 3'd0) begin
                            addr_valid <= 1'b1;
                            addr       <= result;
                        end else if (branchExecute) begin
                            br_taken <= 1'b1;
                        end else begin
                            br_not_taken <= 1'b1;
                        end
                    end else if (wait_cnt == TMAX) begin
                        timeout_err <= 1'b1;
                        resetALU    <= 1'b1;
                        state       <= DRAIN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                RELEASE: state <= DRAIN;

                DRAIN: begin
                    if (!executeComplete && !branchExecute) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: the bench plays the ALU and checks strobes,
// latencies and register contents against hand-derived values.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        aluMode;
    logic [2:0]  op;
    logic [15:0] rd1, rd2;
    logic [5:0]  offset;
    logic        execute;
    logic [15:0] result;
    logic        executeComplete, branchExecute;
    logic        resetALU;
    logic        addr_valid;
    logic [15:0] addr;
    logic        br_taken, br_not_taken, illegal, timeout_err;

    int total = 0;
    int bad = 0;

    // per-instruction observations
    int          n_exec, n_rst, n_addr, n_bt, n_bnt, n_ill, multi;
    int          exec_cyc, rel_cyc, ready_cyc, te_cyc;
    logic        acc_ready, mode_c1;
    logic [2:0]  op_c1;
    logic [15:0] rd1_c1, rd2_c1, addr_obs;
    logic [5:0]  off_c1;
    logic [15:0] rv;

    alu_issue_ctrl #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .aluMode(aluMode), .op(op), .rd1(rd1), .rd2(rd2),
        .offset(offset), .execute(execute), .result(result),
        .executeComplete(executeComplete), .branchExecute(branchExecute),
        .resetALU(resetALU), .addr_valid(addr_valid), .addr(addr),
        .br_taken(br_taken), .br_not_taken(br_not_taken), .illegal(illegal),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] mk(input logic m, input logic [2:0] o,
                                       input logic [2:0] rs, input logic [2:0] rt,
                                       input logic [5:0] off);
        return {m, o, rs, rt, off};
    endfunction

    // Offer one instruction at the current negedge and act as the ALU until the
    // controller is ready again. resp: 0 = executeComplete, 1 = branchExecute, 2 = silent.
    task automatic do_instr(input logic [15:0] ins, input int resp,
                            input logic [15:0] res, input int max_cyc);
        n_exec = 0; n_rst = 0; n_addr = 0; n_bt = 0; n_bnt = 0; n_ill = 0; multi = 0;
        exec_cyc = -1; rel_cyc = -1; ready_cyc = -1; te_cyc = -1;
        instr = ins;
        instr_valid = 1'b1;
        acc_ready = instr_ready;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            instr = 16'h0;
            if (c == 1) begin
                rd1_c1 = rd1; rd2_c1 = rd2; off_c1 = offset; mode_c1 = aluMode; op_c1 = op;
            end
            if (execute) begin
                n_exec++;
                exec_cyc = c;
                if (resp == 0) begin executeComplete = 1'b1; result = res; end
                else if (resp == 1) begin branchExecute = 1'b1; result = res; end
            end
            if (resetALU) begin
                n_rst++;
                rel_cyc = c;
                executeComplete = 1'b0;
                branchExecute = 1'b0;
            end
            if (addr_valid) begin n_addr++; addr_obs = addr; end
            if (br_taken) n_bt++;
            if (br_not_taken) n_bnt++;
            if (illegal) n_ill++;
            if ($countones({addr_valid, br_taken, br_not_taken, illegal}) > 1) multi++;
            if (timeout_err && te_cyc < 0) te_cyc = c;
            if (instr_ready) begin ready_cyc = c; break; end
        end
    endtask

    // Register read-back through rd1 using an address-type instruction.
    task automatic read_reg(input logic [2:0] k, output logic [15:0] v);
        do_instr(mk(1'b0, 3'd0, k, 3'd0, 6'd0), 0, 16'h0, 20);
        v = rd1_c1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; result = '0;
        executeComplete = 1'b0; branchExecute = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({instr_ready, aluMode, op, rd1, rd2, offset, execute, resetALU, addr_valid, addr,
             br_taken, br_not_taken, illegal, timeout_err} !== '0) begin
            $display("FAIL reset_outputs: some output nonzero during reset"); bad++;
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (instr_ready !== 1'b1) begin $display("FAIL reset_ready got=%b want=1", instr_ready); bad++; end
        @(negedge clk);
    endtask

    task automatic test_alu_add;
        do_instr(mk(1'b1, 3'd0, 3'd0, 3'd0, 6'd8), 0, 16'd5, 20);   // r1 = 5
        do_instr(mk(1'b1, 3'd0, 3'd0, 3'd0, 6'd16), 0, 16'd3, 20);  // r2 = 3
        do_instr(mk(1'b1, 3'd0, 3'd1, 3'd2, 6'd24), 0, 16'd8, 20);  // r3 = r1 + r2
        total++; if (acc_ready !== 1'b1) begin $display("FAIL add_accept got=%b want=1", acc_ready); bad++; end
        total++; if (rd1_c1 !== 16'd5) begin $display("FAIL add_rd1 got=%0d want=5", rd1_c1); bad++; end
        total++; if (rd2_c1 !== 16'd3) begin $display("FAIL add_rd2 got=%0d want=3", rd2_c1); bad++; end
        total++; if (mode_c1 !== 1'b1) begin $display("FAIL add_mode got=%b want=1", mode_c1); bad++; end
        total++; if (n_exec !== 1) begin $display("FAIL add_exec_pulses got=%0d want=1", n_exec); bad++; end
        total++; if (exec_cyc !== 2) begin $display("FAIL add_exec_cycle got=%0d want=2", exec_cyc); bad++; end
        total++; if (n_rst !== 1) begin $display("FAIL add_reset_pulses got=%0d want=1", n_rst); bad++; end
        total++; if (rel_cyc !== 4) begin $display("FAIL add_release_latency got=%0d want=4", rel_cyc); bad++; end
        total++; if (ready_cyc !== 6) begin $display("FAIL add_ready_cycle got=%0d want=6", ready_cyc); bad++; end
        total++; if (n_addr + n_bt + n_bnt + n_ill !== 0) begin $display("FAIL add_stray_strobe got=%0d want=0", n_addr + n_bt + n_bnt + n_ill); bad++; end
        read_reg(3'd3, rv);
        total++; if (rv !== 16'd8) begin $display("FAIL add_r3 got=%0d want=8", rv); bad++; end
    endtask

    task automatic test_address;
        do_instr(mk(1'b0, 3'd0, 3'd1, 3'd0, 6'd4), 0, 16'd9, 20);
        total++; if (off_c1 !== 6'd4) begin $display("FAIL addr_offset got=%0d want=4", off_c1); bad++; end
        total++; if (op_c1 !== 3'd0) begin $display("FAIL addr_op got=%0d want=0", op_c1); bad++; end
        total++; if (n_addr !== 1) begin $display("FAIL addr_pulses got=%0d want=1", n_addr); bad++; end
        total++; if (addr_obs !== 16'd9) begin $display("FAIL addr_value got=%0d want=9", addr_obs); bad++; end
        total++; if (multi !== 0) begin $display("FAIL addr_exclusive got=%0d want=0", multi); bad++; end
        read_reg(3'd1, rv);
        total++; if (rv !== 16'd5) begin $display("FAIL addr_r1_kept got=%0d want=5", rv); bad++; end
        read_reg(3'd3, rv);
        total++; if (rv !== 16'd8) begin $display("FAIL addr_r3_kept got=%0d want=8", rv); bad++; end
    endtask

    task automatic test_branch;
        do_instr(mk(1'b0, 3'd1, 3'd1, 3'd2, 6'd0), 1, 16'h0, 20);
        total++; if (n_bt !== 1) begin $display("FAIL br_taken_pulses got=%0d want=1", n_bt); bad++; end
        total++; if (n_bnt !== 0) begin $display("FAIL br_taken_nt got=%0d want=0", n_bnt); bad++; end
        total++; if (n_rst !== 1) begin $display("FAIL br_reset_pulses got=%0d want=1", n_rst); bad++; end
        total++; if (ready_cyc !== 6) begin $display("FAIL br_ready_cycle got=%0d want=6", ready_cyc); bad++; end
        do_instr(mk(1'b0, 3'd2, 3'd1, 3'd2, 6'd0), 0, 16'h0, 20);
        total++; if (n_bnt !== 1) begin $display("FAIL br_not_taken_pulses got=%0d want=1", n_bnt); bad++; end
        total++; if (n_bt !== 0) begin $display("FAIL br_nt_taken got=%0d want=0", n_bt); bad++; end
    endtask

    task automatic test_illegal;
        do_instr(mk(1'b0, 3'd5, 3'd1, 3'd2, 6'd0), 0, 16'h0, 20);
        total++; if (n_ill !== 1) begin $display("FAIL ill_pulses got=%0d want=1", n_ill); bad++; end
        total++; if (n_exec !== 0) begin $display("FAIL ill_exec got=%0d want=0", n_exec); bad++; end
        total++; if (ready_cyc !== 2) begin $display("FAIL ill_ready_cycle got=%0d want=2", ready_cyc); bad++; end
        total++; if (n_rst !== 0) begin $display("FAIL ill_reset_pulses got=%0d want=0", n_rst); bad++; end
    endtask

    task automatic test_r0_write;
        do_instr(mk(1'b1, 3'd3, 3'd0, 3'd0, 6'd0), 0, 16'd77, 20);
        read_reg(3'd0, rv);
        total++; if (rv !== 16'd0) begin $display("FAIL r0_reads_zero got=%0d want=0", rv); bad++; end
    endtask

    task automatic test_timeout;
        result = 16'hdead;
        do_instr(mk(1'b1, 3'd0, 3'd1, 3'd2, 6'd32), 2, 16'hdead, 40);  // rd = 4
        // execute in cycle 2, WAIT cycles 3..18 (counter 0..15), abort seen in cycle 19
        total++; if (te_cyc !== 19) begin $display("FAIL to_err_cycle got=%0d want=19", te_cyc); bad++; end
        total++; if (n_rst !== 1) begin $display("FAIL to_reset_pulses got=%0d want=1", n_rst); bad++; end
        total++; if (rel_cyc !== 19) begin $display("FAIL to_reset_cycle got=%0d want=19", rel_cyc); bad++; end
        total++; if (ready_cyc !== 20) begin $display("FAIL to_ready_cycle got=%0d want=20", ready_cyc); bad++; end
        read_reg(3'd4, rv);
        total++; if (rv !== 16'd0) begin $display("FAIL to_no_writeback got=%0h want=0", rv); bad++; end
        total++; if (timeout_err !== 1'b1) begin $display("FAIL to_sticky got=%b want=1", timeout_err); bad++; end
    endtask

    task automatic test_reset_mid_op;
        instr = mk(1'b1, 3'd0, 3'd1, 3'd2, 6'd24);
        instr_valid = 1'b1;
        @(negedge clk);                  // DECODE
        instr_valid = 1'b0;
        @(negedge clk);                  // ISSUE
        @(negedge clk);                  // WAIT, ALU still silent
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({instr_ready, aluMode, op, rd1, rd2, offset, execute, resetALU, addr_valid, addr,
             br_taken, br_not_taken, illegal, timeout_err} !== '0) begin
            $display("FAIL midrst_outputs: some output nonzero in reset cycle"); bad++;
        end
        @(negedge clk);
        // ALU answers late, after the instruction was aborted
        executeComplete = 1'b1;
        result = 16'h1234;
        rst_n = 1'b1;
        #1;
        total++; if (instr_ready !== 1'b0) begin $display("FAIL midrst_ready_blocked got=%b want=0", instr_ready); bad++; end
        repeat (2) @(negedge clk);
        total++; if (resetALU !== 1'b0) begin $display("FAIL midrst_no_resetalu got=%b want=0", resetALU); bad++; end
        executeComplete = 1'b0;
        #1;
        total++; if (instr_ready !== 1'b1) begin $display("FAIL midrst_ready got=%b want=1", instr_ready); bad++; end
        @(negedge clk);
        read_reg(3'd3, rv);
        total++; if (rv !== 16'd0) begin $display("FAIL midrst_r3 got=%0h want=0", rv); bad++; end
        read_reg(3'd1, rv);
        total++; if (rv !== 16'd0) begin $display("FAIL midrst_r1 got=%0h want=0", rv); bad++; end
    endtask

    initial begin
        test_reset();
        test_alu_add();
        test_address();
        test_branch();
        test_illegal();
        test_r0_write();
        test_timeout();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
